// File: rtl/foo_arb_pkg.sv
// rtl/foo_arb_pkg.sv - shared constants and types for the foo_RTL round-robin arbiter
package foo_arb_pkg;

   localparam int FOO_W     = 4;
   localparam int FOO_N     = 3;
   localparam int FOO_DEPTH = 4;

   typedef logic [$clog2(FOO_N)-1:0] foo_tag_t;

   typedef struct packed {
      logic [FOO_W-1:0] in1;
      logic [FOO_W-1:0] in2;
   } foo_op_t;

endpackage

// File: rtl/foo_tag_fifo.sv
// rtl/foo_tag_fifo.sv - in-order FIFO of requester tags for operations in flight
module foo_tag_fifo
   import foo_arb_pkg::*;
#(
   parameter int DEPTH = FOO_DEPTH,
   parameter int TW    = $bits(foo_tag_t)
) (
   input  logic                     CLK,
   input  logic                     ASYNCRESETN,
   input  logic                     push,
   input  logic [TW-1:0]            push_tag,
   input  logic                     pop,
   output logic [TW-1:0]            pop_tag,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [TW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Guard against overflow/underflow even if the caller forgets to
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_tag = mem[rd_ptr];

   // Tag storage needs no reset; only the pointers define validity
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem[wr_ptr] <= push_tag;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/foo_rr_arbiter.sv
// rtl/foo_rr_arbiter.sv - round-robin share of one foo_RTL among N requesters
module foo_rr_arbiter
   import foo_arb_pkg::*;
#(
   parameter  int N     = FOO_N,
   parameter  int W     = FOO_W,
   parameter  int DEPTH = FOO_DEPTH,
   localparam int TW    = $clog2(N),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic            CLK,
   input  logic            ASYNCRESETN,
   input  logic [N-1:0]    req_valid,
   output logic [N-1:0]    req_ready,
   input  logic [N*W-1:0]  req_in1,
   input  logic [N*W-1:0]  req_in2,
   output logic            dn_valid,
   input  logic            dn_ready,
   output logic [W-1:0]    dn_in1,
   output logic [W-1:0]    dn_in2,
   output logic [TW-1:0]   dn_tag,
   input  logic            up_rsp_valid,
   input  logic            up_rsp_data,
   output logic [N-1:0]    rsp_valid,
   output logic [N-1:0]    rsp_data,
   output logic [CW-1:0]   inflight,
   output logic            err_unexp_rsp
);

   logic [TW-1:0] ptr;
   logic [N-1:0]  grant;
   logic [TW-1:0] gnt_idx;
   logic          found;
   logic [TW-1:0] cand;
   logic [W-1:0]  sel_in1;
   logic [W-1:0]  sel_in2;
   logic          load_ok;
   logic          accept;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [TW-1:0] head_tag;

   // A new op may load only when the stage is free or draining and a tag slot exists
   assign load_ok  = (!dn_valid || dn_ready) && !fifo_full;
   assign req_ready = grant & {N{load_ok && ASYNCRESETN}};
   assign accept   = |req_ready;
   assign fifo_pop = up_rsp_valid && !fifo_empty;

   // Round-robin search: first valid requester at or after ptr, wrapping mod N
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = TW'((int'(ptr) + k) % N);
         if (!found && req_valid[cand]) begin
            grant[cand] = 1'b1;
            gnt_idx     = cand;
            found       = 1'b1;
         end
      end
   end

   // Operand mux driven by the one-hot grant
   always_comb begin
      sel_in1 = '0;
      sel_in2 = '0;
      for (int k = 0; k < N; k++) begin
         if (grant[k]) begin
            sel_in1 = req_in1[k*W +: W];
            sel_in2 = req_in2[k*W +: W];
         end
      end
   end

   // Output stage: load on accept, hold while stalled, clear once drained
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         dn_valid <= 1'b0;
         dn_in1   <= '0;
         dn_in2   <= '0;
         dn_tag   <= '0;
         ptr      <= '0;
      end else if (accept) begin
         dn_valid <= 1'b1;
         dn_in1   <= sel_in1;
         dn_in2   <= sel_in2;
         dn_tag   <= gnt_idx;
         ptr      <= (gnt_idx == TW'(N-1)) ? '0 : gnt_idx + TW'(1);
      end else if (dn_valid && dn_ready) begin
         dn_valid <= 1'b0;
      end
   end

   // Route each result to the requester at the FIFO head; flag orphan responses
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         rsp_valid     <= '0;
         rsp_data      <= '0;
         err_unexp_rsp <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         if (fifo_pop) begin
            rsp_valid[head_tag] <= 1'b1;
            rsp_data[head_tag]  <= up_rsp_data;
         end
         if (up_rsp_valid && fifo_empty) begin
            err_unexp_rsp <= 1'b1;
         end
      end
   end

   foo_tag_fifo #(
      .DEPTH (DEPTH),
      .TW    (TW)
   ) u_tag_fifo (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .push        (accept),
      .push_tag    (gnt_idx),
      .pop         (fifo_pop),
      .pop_tag     (head_tag),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (inflight)
   );

endmodule

// File: tb/tb_foo_rr_arbiter.sv
// tb/tb_foo_rr_arbiter.sv - directed self-checking bench for foo_rr_arbiter
module tb_foo_rr_arbiter;

   logic        CLK = 1'b0;
   logic        ASYNCRESETN;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [11:0] req_in1;
   logic [11:0] req_in2;
   logic        dn_valid;
   logic        dn_ready;
   logic [3:0]  dn_in1;
   logic [3:0]  dn_in2;
   logic [1:0]  dn_tag;
   logic        up_rsp_valid;
   logic        up_rsp_data;
   logic [2:0]  rsp_valid;
   logic [2:0]  rsp_data;
   logic [2:0]  inflight;
   logic        err_unexp_rsp;

   int checks = 0;
   int errors = 0;

   foo_rr_arbiter dut (
      .CLK           (CLK),
      .ASYNCRESETN   (ASYNCRESETN),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_in1       (req_in1),
      .req_in2       (req_in2),
      .dn_valid      (dn_valid),
      .dn_ready      (dn_ready),
      .dn_in1        (dn_in1),
      .dn_in2        (dn_in2),
      .dn_tag        (dn_tag),
      .up_rsp_valid  (up_rsp_valid),
      .up_rsp_data   (up_rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .inflight      (inflight),
      .err_unexp_rsp (err_unexp_rsp)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      req_valid    = '0;
      up_rsp_valid = 1'b0;
      up_rsp_data  = 1'b0;
      dn_ready     = 1'b0;
      ASYNCRESETN  = 1'b0;
      tick();
      tick();
      ASYNCRESETN  = 1'b1;
   endtask

   task automatic test_reset();
      ASYNCRESETN  = 1'b1;
      req_valid    = 3'b111;
      req_in1      = 12'h321;
      req_in2      = 12'hCBA;
      dn_ready     = 1'b1;
      up_rsp_valid = 1'b0;
      up_rsp_data  = 1'b0;
      #2;
      ASYNCRESETN  = 1'b0;
      tick();
      tick();
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b exp 000", req_ready); end
      checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid: got %b exp 0", dn_valid); end
      checks++; if ({dn_in1, dn_in2, dn_tag} !== 10'd0) begin errors++; $display("FAIL reset_dn_data: got %h exp 0", {dn_in1, dn_in2, dn_tag}); end
      checks++; if (rsp_valid !== 3'b000 || rsp_data !== 3'b000) begin errors++; $display("FAIL reset_rsp: got %b/%b exp 000/000", rsp_valid, rsp_data); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d exp 0", inflight); end
      checks++; if (err_unexp_rsp !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_unexp_rsp); end
      req_valid   = '0;
      ASYNCRESETN = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      dn_ready  = 1'b1;
      req_in1   = 12'h0F0;
      req_in2   = 12'h030;
      req_valid = 3'b010;
      #1;
      checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_req_ready: got %b exp 010", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL single_dn_valid: got %b exp 1", dn_valid); end
      checks++; if (dn_in1 !== 4'hF || dn_in2 !== 4'h3) begin errors++; $display("FAIL single_dn_ops: got %h/%h exp F/3", dn_in1, dn_in2); end
      checks++; if (dn_tag !== 2'd1) begin errors++; $display("FAIL single_dn_tag: got %0d exp 1", dn_tag); end
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL single_inflight: got %0d exp 1", inflight); end
      up_rsp_valid = 1'b1;
      up_rsp_data  = 1'b1;
      tick();
      up_rsp_valid = 1'b0;
      up_rsp_data  = 1'b0;
      checks++; if (rsp_valid !== 3'b010) begin errors++; $display("FAIL single_rsp_valid: got %b exp 010", rsp_valid); end
      checks++; if (rsp_data[1] !== 1'b1) begin errors++; $display("FAIL single_rsp_data: got %b exp 1", rsp_data[1]); end
      checks++; if (dn_valid !== 1'b0 || inflight !== 3'd0) begin errors++; $display("FAIL single_drain: got dn_valid=%b inflight=%0d exp 0/0", dn_valid, inflight); end
      tick();
      checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_rsp_pulse: got %b exp 000", rsp_valid); end
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 2, 0, 1, 2};
      do_reset();
      dn_ready  = 1'b1;
      req_in1   = 12'h321;
      req_in2   = 12'hCBA;
      req_valid = 3'b111;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (req_ready !== 3'(1 << order[c])) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", c, req_ready, 3'(1 << order[c])); end
         tick();
         checks++; if (dn_tag !== 2'(order[c]) || dn_in1 !== 4'(order[c] + 1)) begin errors++; $display("FAIL rr_stage%0d: got tag=%0d in1=%h exp tag=%0d in1=%0d", c, dn_tag, dn_in1, order[c], order[c] + 1); end
         checks++; if (inflight !== 3'(c + 1)) begin errors++; $display("FAIL rr_inflight%0d: got %0d exp %0d", c, inflight, c + 1); end
      end
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rr_full_block: got %b exp 000", req_ready); end
      up_rsp_valid = 1'b1;
      up_rsp_data  = 1'b0;
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rr_full_pop_noslot: got %b exp 000", req_ready); end
      tick();
      checks++; if (inflight !== 3'd3 || rsp_valid !== 3'b001) begin errors++; $display("FAIL rr_first_pop: got inflight=%0d rsp=%b exp 3/001", inflight, rsp_valid); end
      for (int c = 4; c < 6; c++) begin
         #1;
         checks++; if (req_ready !== 3'(1 << order[c])) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", c, req_ready, 3'(1 << order[c])); end
         tick();
         checks++; if (dn_tag !== 2'(order[c])) begin errors++; $display("FAIL rr_tag%0d: got %0d exp %0d", c, dn_tag, order[c]); end
         checks++; if (inflight !== 3'd3 || rsp_valid !== 3'(1 << (c - 3))) begin errors++; $display("FAIL rr_pushpop%0d: got inflight=%0d rsp=%b exp 3/%b", c, inflight, rsp_valid, 3'(1 << (c - 3))); end
      end
      up_rsp_valid = 1'b0;
      req_valid    = '0;
   endtask

   task automatic test_backpressure();
      do_reset();
      dn_ready  = 1'b0;
      req_in1   = 12'h00A;
      req_in2   = 12'h005;
      req_valid = 3'b001;
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_first_ready: got %b exp 001", req_ready); end
      tick();
      req_valid = 3'b111;
      req_in1   = 12'h555;
      req_in2   = 12'h666;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_ready%0d: got %b exp 000", c, req_ready); end
         checks++; if (dn_valid !== 1'b1 || dn_in1 !== 4'hA || dn_in2 !== 4'h5 || dn_tag !== 2'd0) begin errors++; $display("FAIL bp_hold%0d: got v=%b in1=%h in2=%h tag=%0d exp 1/A/5/0", c, dn_valid, dn_in1, dn_in2, dn_tag); end
         tick();
      end
      dn_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_release: got %b exp 010", req_ready); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_in_order();
      logic [2:0] issue [3] = '{3'b100, 3'b001, 3'b010};
      int         tags  [3] = '{2, 0, 1};
      logic       data  [3] = '{1'b1, 1'b0, 1'b1};
      do_reset();
      dn_ready = 1'b1;
      req_in1  = 12'h987;
      req_in2  = 12'h123;
      for (int c = 0; c < 3; c++) begin
         req_valid = issue[c];
         #1;
         checks++; if (req_ready !== issue[c]) begin errors++; $display("FAIL order_issue%0d: got %b exp %b", c, req_ready, issue[c]); end
         tick();
      end
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         up_rsp_valid = 1'b1;
         up_rsp_data  = data[c];
         tick();
         checks++; if (rsp_valid !== 3'(1 << tags[c])) begin errors++; $display("FAIL order_rsp_valid%0d: got %b exp %b", c, rsp_valid, 3'(1 << tags[c])); end
         checks++; if (rsp_data[tags[c]] !== data[c]) begin errors++; $display("FAIL order_rsp_data%0d: got %b exp %b", c, rsp_data[tags[c]], data[c]); end
      end
      up_rsp_valid = 1'b0;
      up_rsp_data  = 1'b0;
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL order_drained: got %0d exp 0", inflight); end
   endtask

   task automatic test_error_reset();
      do_reset();
      up_rsp_valid = 1'b1;
      up_rsp_data  = 1'b1;
      tick();
      up_rsp_valid = 1'b0;
      checks++; if (err_unexp_rsp !== 1'b1) begin errors++; $display("FAIL err_set: got %b exp 1", err_unexp_rsp); end
      checks++; if (rsp_valid !== 3'b000 || inflight !== 3'd0) begin errors++; $display("FAIL err_no_pop: got rsp=%b inflight=%0d exp 000/0", rsp_valid, inflight); end
      tick();
      tick();
      checks++; if (err_unexp_rsp !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", err_unexp_rsp); end
      dn_ready  = 1'b1;
      req_in1   = 12'h0C7;
      req_in2   = 12'h000;
      req_valid = 3'b001;
      tick();
      req_valid = 3'b010;
      tick();
      req_valid = '0;
      dn_ready  = 1'b0;
      #1;
      checks++; if (dn_valid !== 1'b1 || inflight !== 3'd2) begin errors++; $display("FAIL err_pre_reset: got v=%b inflight=%0d exp 1/2", dn_valid, inflight); end
      #2;
      ASYNCRESETN = 1'b0;
      #1;
      checks++; if (dn_valid !== 1'b0 || inflight !== 3'd0 || err_unexp_rsp !== 1'b0) begin errors++; $display("FAIL err_async_reset: got v=%b inflight=%0d err=%b exp 0/0/0", dn_valid, inflight, err_unexp_rsp); end
      checks++; if (dn_in1 !== 4'h0 || dn_tag !== 2'd0) begin errors++; $display("FAIL err_async_stage: got in1=%h tag=%0d exp 0/0", dn_in1, dn_tag); end
      tick();
      ASYNCRESETN  = 1'b1;
      up_rsp_valid = 1'b1;
      tick();
      up_rsp_valid = 1'b0;
      checks++; if (err_unexp_rsp !== 1'b1 || rsp_valid !== 3'b000) begin errors++; $display("FAIL err_after_reset: got err=%b rsp=%b exp 1/000", err_unexp_rsp, rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_in_order();
      test_error_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
